// File: rtl/rx_fifo_32_pkg.sv
// Shared definitions for the rx_fifo_32 receive FIFO: occupancy state
// encodings, default geometry and the occupancy state transition function.
package rx_fifo_32_pkg;

  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AF_LEVEL = 6;
  localparam int DEF_AE_LEVEL = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY   = 2'b00;
  localparam state_t ST_PARTIAL = 2'b01;
  localparam state_t ST_FULL    = 2'b10;

  // Push-only and pop-only are the only events that move the occupancy state;
  // simultaneous push and pop (or neither) always holds.
  function automatic state_t next_state(input state_t cur,
                                        input logic   push_only,
                                        input logic   pop_only,
                                        input logic   at_top,
                                        input logic   at_one);
    state_t nxt;
    nxt = cur;
    case (cur)
      ST_EMPTY:   if (push_only) nxt = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push_only && at_top)     nxt = ST_FULL;
        else if (pop_only && at_one) nxt = ST_EMPTY;
      end
      ST_FULL:    if (pop_only) nxt = ST_PARTIAL;
      default:    nxt = ST_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rx_fifo_32_if.sv
// Handshake and status bundle between the word producer/consumer and rx_fifo_32.
// Error reporting signals exist only when RX_FIFO_ERR_EN is defined.
interface rx_fifo_32_if #(parameter int DEPTH = 8) ();

  logic [31:0]              data_in;
  logic                     valid_in;
  logic                     pop;
  logic [31:0]              data_out;
  logic                     valid_out;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
`ifdef RX_FIFO_ERR_EN
  logic                     overflow;
  logic                     underflow;
  logic [7:0]               drop_cnt;
`endif

  modport master (
    output data_in, valid_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count
`ifdef RX_FIFO_ERR_EN
    , overflow, underflow, drop_cnt
`endif
  );

  modport slave (
    input  data_in, valid_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, count
`ifdef RX_FIFO_ERR_EN
    , overflow, underflow, drop_cnt
`endif
  );

endinterface

// File: rtl/rx_fifo_32_mem.sv
// rx_fifo_mem: DEPTH x 32 register array with one write port and one
// registered read port; the read register clears on reset, the array does not.
module rx_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_f,
  input  logic          reset_L,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; stale words are unreachable because the
  // pointers and occupancy restart from zero, and this keeps it mappable to RAM.
  always_ff @(posedge clk_f) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A same-address write in this cycle is not visible here: the read sees the
  // old word, which is what a push+pop on a full FIFO needs.
  always_ff @(posedge clk_f) begin
    if (!reset_L)   rd_data <= 32'h0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_fifo_32.sv
// rx_fifo_32: word FIFO behind phy_rx with registered read data and status.
// Optional error reporting (overflow/underflow/drop_cnt) under RX_FIFO_ERR_EN.
module rx_fifo_32
  import rx_fifo_32_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic         clk_f,
  input  logic         reset_L,
  rx_fifo_32_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_nxt;
  state_t        state_q, state_nxt;
  logic          full_q, empty_q, af_q, ae_q, valid_q;
  logic          push_ok, pop_ok, push_only, pop_only;

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign pop_ok    = bus.pop && !empty_q;
  assign push_ok   = bus.valid_in && (!full_q || pop_ok);
  assign push_only = push_ok && !pop_ok;
  assign pop_only  = pop_ok && !push_ok;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count_q;
    if (push_only)     count_nxt = count_q + CW'(1);
    else if (pop_only) count_nxt = count_q - CW'(1);
    state_nxt = next_state(state_q, push_only, pop_only,
                           count_q == CW'(DEPTH - 1), count_q == CW'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      state_q <= ST_EMPTY;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_nxt;
      state_q <= state_nxt;
      empty_q <= (state_nxt == ST_EMPTY);
      full_q  <= (state_nxt == ST_FULL);
      af_q    <= (count_nxt >= CW'(AF_LEVEL));
      ae_q    <= (count_nxt <= CW'(AE_LEVEL));
      valid_q <= pop_ok;
    end
  end

  rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

  assign bus.valid_out    = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;

`ifdef RX_FIFO_ERR_EN
  logic       overflow_q, underflow_q;
  logic [7:0] drop_cnt_q;
  logic       drop;

  assign drop = bus.valid_in && !push_ok;

  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_cnt_q  <= 8'h00;
    end else begin
      if (drop)                          overflow_q  <= 1'b1;
      if (bus.pop && empty_q)            underflow_q <= 1'b1;
      if (drop && drop_cnt_q != 8'hFF)   drop_cnt_q  <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
`endif

endmodule
